// File: rtl/muldiv_seq.sv
// Unsigned MUL/DIV sequencer for the 8088 execution unit: shift-and-add multiply
// and restoring divide, one bit per three-cycle slot on the shared ALU.
module muldiv_seq (
   input  logic        CLKx4,
   input  logic        RESET,
   input  logic        start,
   input  logic        isDiv,
   input  logic        byteWord,
   input  logic [15:0] srcOp,
   input  logic [15:0] accHi,
   input  logic [15:0] accLo,
   output logic        busy,
   output logic        done,
   output logic        divError,
   output logic [15:0] resultHi,
   output logic [15:0] resultLo,
   output logic [15:0] aluA,
   output logic [15:0] aluB,
   output logic [3:0]  aluOp,
   output logic        aluByteWord,
   output logic        aluCarryIn,
   input  logic [15:0] aluS,
   input  logic        aluCarry
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT2, DONE} stateType;

   localparam logic [3:0] opAdd = 4'b1000;
   localparam logic [3:0] opSub = 4'b1101;
   localparam logic [3:0] opCmp = 4'b1111;

   stateType    state;
   logic        divMode;
   logic        checkSlot;
   logic [15:0] hi;
   logic [15:0] lo;
   logic [15:0] divisor;
   logic [3:0]  stepCnt;

   logic        wordSel;
   logic        divSel;
   logic        restore;
   logic        srcChk;
   logic        lastStep;
   logic [15:0] mask;
   logic [15:0] capHi;
   logic [15:0] capLo;
   logic [15:0] srcHi;
   logic [15:0] srcLo;
   logic [15:0] srcD;
   logic [15:0] issueA;
   logic [15:0] issueB;
   logic [3:0]  issueOp;

   assign aluCarryIn = 1'b0;
   assign lastStep   = (stepCnt == (aluByteWord ? 4'd15 : 4'd7));

   // Capture of the finishing slot, then operands for the slot that follows it.
   // In IDLE the operands come straight from the inputs so the first ISSUE is ready.
   always_comb begin
      wordSel = (state == IDLE) ? byteWord : aluByteWord;
      divSel  = (state == IDLE) ? isDiv : divMode;
      mask    = wordSel ? 16'hFFFF : 16'h00FF;
      restore = 1'b0;
      capHi   = hi;
      capLo   = lo;
      if (!checkSlot) begin
         if (divSel) begin
            restore = (wordSel ? hi[15] : hi[7]) | ~aluCarry;
            capHi   = restore ? (aluS & mask) : aluA;
            capLo   = ((lo << 1) | {15'd0, restore}) & mask;
         end else if (wordSel) begin
            capHi = {aluCarry, aluS[15:1]};
            capLo = {aluS[0], lo[15:1]};
         end else begin
            capHi = {8'h00, aluCarry, aluS[7:1]};
            capLo = {8'h00, aluS[0], lo[7:1]};
         end
      end
      if (state == IDLE) begin
         srcHi  = isDiv ? (accHi & mask) : 16'h0000;
         srcLo  = accLo & mask;
         srcD   = srcOp & mask;
         srcChk = isDiv;
      end else begin
         srcHi  = capHi;
         srcLo  = capLo;
         srcD   = divisor;
         srcChk = 1'b0;
      end
      if (srcChk) begin
         issueOp = opCmp;
         issueA  = srcHi;
         issueB  = srcD;
      end else if (divSel) begin
         issueOp = opSub;
         issueA  = ((srcHi << 1) | {15'd0, (wordSel ? srcLo[15] : srcLo[7])}) & mask;
         issueB  = srcD;
      end else begin
         issueOp = opAdd;
         issueA  = srcHi;
         issueB  = srcLo[0] ? srcD : 16'h0000;
      end
   end

   always_ff @(posedge CLKx4) begin
      if (RESET) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         divError    <= 1'b0;
         resultHi    <= 16'h0000;
         resultLo    <= 16'h0000;
         aluA        <= 16'h0000;
         aluB        <= 16'h0000;
         aluOp       <= opAdd;
         aluByteWord <= 1'b0;
         divMode     <= 1'b0;
         checkSlot   <= 1'b0;
         hi          <= 16'h0000;
         lo          <= 16'h0000;
         divisor     <= 16'h0000;
         stepCnt     <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  divMode     <= isDiv;
                  aluByteWord <= byteWord;
                  checkSlot   <= isDiv;
                  hi          <= srcHi;
                  lo          <= srcLo;
                  divisor     <= srcD;
                  stepCnt     <= 4'd0;
                  busy        <= 1'b1;
                  aluA        <= issueA;
                  aluB        <= issueB;
                  aluOp       <= issueOp;
                  state       <= ISSUE;
               end
            end
            ISSUE: state <= WAIT1;
            WAIT1: state <= WAIT2;
            WAIT2: begin
               if (checkSlot && !aluCarry) begin
                  // Quotient cannot fit (or divisor is zero): report the dividend untouched.
                  divError <= 1'b1;
                  resultHi <= hi;
                  resultLo <= lo;
                  done     <= 1'b1;
                  aluA     <= 16'h0000;
                  aluB     <= 16'h0000;
                  aluOp    <= opAdd;
                  state    <= DONE;
               end else if (!checkSlot && lastStep) begin
                  hi       <= capHi;
                  lo       <= capLo;
                  divError <= 1'b0;
                  resultHi <= capHi;
                  resultLo <= capLo;
                  done     <= 1'b1;
                  aluA     <= 16'h0000;
                  aluB     <= 16'h0000;
                  aluOp    <= opAdd;
                  state    <= DONE;
               end else begin
                  checkSlot <= 1'b0;
                  hi        <= capHi;
                  lo        <= capLo;
                  if (!checkSlot) stepCnt <= stepCnt + 4'd1;
                  aluA      <= issueA;
                  aluB      <= issueB;
                  aluOp     <= issueOp;
                  state     <= ISSUE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: models the shared ALU pipeline and checks
// results, latency and slot behaviour against plain-arithmetic MUL/DIV.
module tb_muldiv_seq;

   logic        CLKx4 = 1'b0;
   logic        RESET = 1'b1;
   logic        start = 1'b0;
   logic        isDiv = 1'b0;
   logic        byteWord = 1'b0;
   logic [15:0] srcOp = 16'h0000;
   logic [15:0] accHi = 16'h0000;
   logic [15:0] accLo = 16'h0000;
   logic        busy, done, divError, aluByteWord, aluCarryIn;
   logic [15:0] resultHi, resultLo, aluA, aluB;
   logic [3:0]  aluOp;
   logic [15:0] aluS = 16'h0000;
   logic        aluCarry = 1'b0;
   logic        aluCarryPipe = 1'b0;
   logic [16:0] aluRes;

   int    compared = 0;
   int    mismatched = 0;
   string opName = "reset";

   muldiv_seq dut (
      .CLKx4(CLKx4), .RESET(RESET), .start(start), .isDiv(isDiv), .byteWord(byteWord),
      .srcOp(srcOp), .accHi(accHi), .accLo(accLo), .busy(busy), .done(done),
      .divError(divError), .resultHi(resultHi), .resultLo(resultLo), .aluA(aluA),
      .aluB(aluB), .aluOp(aluOp), .aluByteWord(aluByteWord), .aluCarryIn(aluCarryIn),
      .aluS(aluS), .aluCarry(aluCarry)
   );

   always #5 CLKx4 = ~CLKx4;

   // Shared ALU: result one cycle after operands, carry/borrow two cycles after.
   function automatic logic [16:0] aluModel(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op, input logic bw);
      logic [31:0] aa, bb, r;
      logic        c;
      aa = bw ? {16'h0, a} : {24'h0, a[7:0]};
      bb = bw ? {16'h0, b} : {24'h0, b[7:0]};
      if (op == 4'b1000) begin
         r = aa + bb;
         c = bw ? r[16] : r[8];
      end else begin
         r = aa - bb;
         c = (aa < bb);
      end
      return {c, (bw ? r[15:0] : {8'h00, r[7:0]})};
   endfunction

   always @(posedge CLKx4) begin
      aluRes = aluModel(aluA, aluB, aluOp, aluByteWord);
      aluS <= aluRes[15:0];
      aluCarryPipe <= aluRes[16];
      aluCarry <= aluCarryPipe;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", opName, tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge CLKx4);
      #1;
   endtask

   // Runs one operation from the cycle start is raised up to the cycle after done.
   task automatic applyStimulus(input logic opDiv, input logic bw, input logic [15:0] src,
                                input logic [15:0] hiIn, input logic [15:0] loIn,
                                input bit pokeStart);
      logic [15:0] m, srcM, hiM, loM, expHi, expLo, recA, recB;
      logic [31:0] prod, dividend, q, r;
      logic [3:0]  recOp, expOp;
      logic        expErr;
      int          n, expCycles, c;
      bit          doneSeen, stable, opOk, upperOk, busyOk;
      n    = bw ? 16 : 8;
      m    = bw ? 16'hFFFF : 16'h00FF;
      srcM = src & m;
      hiM  = hiIn & m;
      loM  = loIn & m;
      expErr = 1'b0;
      recA = 16'h0; recB = 16'h0; recOp = 4'h0;
      if (!opDiv) begin
         prod  = {16'h0, srcM} * {16'h0, loM};
         expHi = bw ? prod[31:16] : {8'h00, prod[15:8]};
         expLo = bw ? prod[15:0] : {8'h00, prod[7:0]};
         expCycles = 3 * n + 1;
      end else if (hiM >= srcM) begin
         expErr = 1'b1;
         expHi = hiM;
         expLo = loM;
         expCycles = 4;
      end else begin
         dividend = bw ? {hiM, loM} : {16'h0, hiM[7:0], loM[7:0]};
         q = dividend / {16'h0, srcM};
         r = dividend % {16'h0, srcM};
         expHi = r[15:0];
         expLo = q[15:0];
         expCycles = 3 * (n + 1) + 1;
      end

      isDiv = opDiv; byteWord = bw; srcOp = src; accHi = hiIn; accLo = loIn; start = 1'b1;
      nextCycle();
      start = 1'b0;
      c = 1; doneSeen = 0; stable = 1; opOk = 1; upperOk = 1; busyOk = 1;
      while (c <= 80 && !doneSeen) begin
         srcOp = 16'($urandom); accHi = 16'($urandom); accLo = 16'($urandom);
         isDiv = 1'($urandom); byteWord = 1'($urandom);
         start = (pokeStart && c == 5);
         if (!busy) busyOk = 0;
         if (done) begin
            doneSeen = 1;
         end else begin
            expOp = !opDiv ? 4'b1000 : (((c - 1) / 3 == 0) ? 4'b1111 : 4'b1101);
            if ((c - 1) % 3 == 0) begin
               recA = aluA; recB = aluB; recOp = aluOp;
            end else if (aluA !== recA || aluB !== recB || aluOp !== recOp) begin
               stable = 0;
            end
            if (aluOp !== expOp || aluByteWord !== bw) opOk = 0;
            if (!bw && (aluA[15:8] != 8'h00 || aluB[15:8] != 8'h00)) upperOk = 0;
            nextCycle();
            c++;
         end
      end
      start = 1'b0;
      checkOutput("doneCycle", 32'(c), 32'(expCycles));
      checkOutput("divError", {31'd0, divError}, {31'd0, expErr});
      checkOutput("resultHi", {16'h0, resultHi}, {16'h0, expHi});
      checkOutput("resultLo", {16'h0, resultLo}, {16'h0, expLo});
      checkOutput("busyWhileRunning", {31'd0, busyOk}, 32'd1);
      checkOutput("slotStable", {31'd0, stable}, 32'd1);
      checkOutput("slotOpcode", {31'd0, opOk}, 32'd1);
      checkOutput("byteUpperZero", {31'd0, upperOk}, 32'd1);
      checkOutput("aluIdleAtDone", {12'h0, aluOp, aluA}, {12'h0, 4'b1000, 16'h0});
      checkOutput("aluBIdleAtDone", {15'h0, aluCarryIn, aluB}, 32'h0);
      nextCycle();
      checkOutput("afterDone", {30'd0, busy, done}, 32'd0);
      checkOutput("resultsHeld", {resultHi, resultLo}, {expHi, expLo});
   endtask

   initial begin
      logic        rDiv, rBw;
      logic [15:0] d, h, l, s;
      bit          doneLeak;

      RESET = 1'b1;
      repeat (3) nextCycle();
      checkOutput("resetFlags", {29'd0, busy, done, divError}, 32'd0);
      checkOutput("resetResults", {resultHi, resultLo}, 32'd0);
      checkOutput("resetAlu", {aluA, aluB}, 32'd0);
      checkOutput("resetAluCtl", {26'd0, aluOp, aluByteWord, aluCarryIn}, {26'd0, 4'b1000, 2'b00});
      RESET = 1'b0;
      nextCycle();

      opName = "mulByteFF"; applyStimulus(1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h00FF, 1'b0);
      opName = "mulWord";   applyStimulus(1'b0, 1'b1, 16'h1234, 16'h0000, 16'h5678, 1'b0);
      opName = "divWord";   applyStimulus(1'b1, 1'b1, 16'h0003, 16'h0001, 16'h0000, 1'b1);
      opName = "divByte";   applyStimulus(1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0064, 1'b0);
      opName = "divErrEq";  applyStimulus(1'b1, 1'b1, 16'h0005, 16'h0005, 16'h1111, 1'b0);
      opName = "divErrZero"; applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0012, 16'h0034, 1'b0);
      opName = "mulPoked";  applyStimulus(1'b0, 1'b0, 16'hAB81, 16'h0000, 16'h77C3, 1'b1);
      opName = "divAfterErr"; applyStimulus(1'b1, 1'b0, 16'h0010, 16'h000F, 16'h00FF, 1'b0);

      opName = "resetMidMul";
      isDiv = 1'b0; byteWord = 1'b1; srcOp = 16'h1234; accLo = 16'h5678; start = 1'b1;
      nextCycle();
      start = 1'b0;
      repeat (9) nextCycle();
      checkOutput("busyBeforeReset", {31'd0, busy}, 32'd1);
      RESET = 1'b1;
      nextCycle();
      RESET = 1'b0;
      checkOutput("flagsAfterReset", {29'd0, busy, done, divError}, 32'd0);
      checkOutput("resultsAfterReset", {resultHi, resultLo}, 32'd0);
      checkOutput("aluAfterReset", {aluA, aluB}, 32'd0);
      checkOutput("aluCtlAfterReset", {27'd0, aluOp, aluByteWord}, {27'd0, 4'b1000, 1'b0});
      doneLeak = 0;
      repeat (60) begin
         if (done || busy) doneLeak = 1;
         nextCycle();
      end
      checkOutput("noDoneAfterReset", {31'd0, doneLeak}, 32'd0);

      opName = "resetWithStart";
      RESET = 1'b1; start = 1'b1;
      nextCycle();
      RESET = 1'b0; start = 1'b0;
      checkOutput("busyAfterResetStart", {31'd0, busy}, 32'd0);
      nextCycle();
      checkOutput("stillIdle", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         opName = $sformatf("rand%0d", i);
         rDiv = 1'($urandom);
         rBw  = 1'($urandom);
         if (rDiv) begin
            d = rBw ? 16'($urandom) : {8'h00, 8'($urandom)};
            if ($urandom_range(0, 4) == 0) d = 16'h0000;
            if ($urandom_range(0, 3) == 0 || d == 16'h0000)
               h = rBw ? 16'($urandom) : {8'h00, 8'($urandom)};
            else
               h = 16'($urandom % {16'h0, d});
            s = rBw ? d : {8'($urandom), d[7:0]};
         end else begin
            h = 16'h0000;
            s = 16'($urandom);
         end
         l = 16'($urandom);
         applyStimulus(rDiv, rBw, s, h, l, ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) nextCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
